// File: rtl/flash_arb_pkg.sv
// Shared state encoding and SPI flash command constants for flash_access_arbiter.
package flash_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DATA  = 3'd3,
      ST_STALL = 3'd4,
      ST_DESEL = 3'd5
   } state_t;

   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;
   localparam int         ADDR_BYTES   = 3;

endpackage

// File: rtl/flash_access_arbiter_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 1 (deasserted csb).
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/flash_access_arbiter.sv
// Shares the SPI flash between a host pass-through and an internal sequential read engine.
// Build option FLASH_FAST_READ_EN selects opcode 0x0B with one dummy byte instead of 0x03.
module flash_access_arbiter
   import flash_arb_pkg::*;
#(
   parameter int ADDR_W  = 24,
   parameter int LEN_W   = 16,
   parameter int SCK_DIV = 1,
   parameter int DESEL   = 2
) (
   input  logic              CLK12,
   input  logic              RST,
   input  logic              host_csb,
   input  logic              host_sck,
   input  logic              host_mosi,
   output logic              host_miso,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [LEN_W-1:0]  rd_len,
   output logic              rd_busy,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_done,
   output logic              host_coll,
   output logic              flash_csb,
   output logic              flash_sck,
   output logic              flash_d0,
   input  logic              flash_d1,
   output logic              flash_d2,
   output logic              flash_d3,
   output logic [2:0]        dbg_state_o
);

`ifdef FLASH_FAST_READ_EN
   localparam logic [7:0] OPCODE  = OP_FAST_READ;
   localparam int         DUMMY_W = 8;
`else
   localparam logic [7:0] OPCODE  = OP_READ;
   localparam int         DUMMY_W = 0;
`endif
   localparam int HDR_W = 8 + ADDR_BYTES * 8 + DUMMY_W;
   localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int DSL_W = (DESEL > 1) ? $clog2(DESEL) : 1;

   // Handshake: a byte transfers on any CLK12 edge where rd_valid && rd_ready;
   // rd_valid stays high with rd_data stable until that edge.

   state_t                  state_q, state_d;
   logic                    sck_q, sck_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [5:0]              bit_q, bit_d;
   logic [HDR_W-1:0]        tx_q, tx_d;
   logic [7:0]              rx_q, rx_d;
   logic [7:0]              data_q, data_d;
   logic                    valid_q, valid_d;
   logic [LEN_W-1:0]        rem_q, rem_d;
   logic [DSL_W-1:0]        dsl_q, dsl_d;
   logic                    hcs_prev_q;
   logic                    coll_q, coll_d;

   logic                    hcs_s;
   logic                    accept_ok;
   logic                    hs;
   logic                    tick;
   logic                    pass;
   logic [ADDR_BYTES*8-1:0] addr_wire;

   sync_2ff u_hcs_sync (
      .clk_i (CLK12),
      .rst_i (RST),
      .d_i   (host_csb),
      .q_o   (hcs_s)
   );

   assign addr_wire = (ADDR_BYTES*8)'(rd_addr);
   assign accept_ok = rd_req && hcs_s && hcs_prev_q;
   assign hs        = valid_q && rd_ready;
   assign tick      = (div_q == DIV_W'(SCK_DIV - 1));

   always_ff @(posedge CLK12 or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         sck_q      <= 1'b0;
         div_q      <= '0;
         bit_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         rem_q      <= '0;
         dsl_q      <= '0;
         hcs_prev_q <= 1'b1;
         coll_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sck_q      <= sck_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         rem_q      <= rem_d;
         dsl_q      <= dsl_d;
         hcs_prev_q <= hcs_s;
         coll_q     <= coll_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sck_d   = sck_q;
      div_d   = div_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      data_d  = data_q;
      valid_d = valid_q;
      rem_d   = rem_q;
      dsl_d   = dsl_q;
      coll_d  = coll_q;

      if (hs) begin
         valid_d = 1'b0;
         rem_d   = rem_q - LEN_W'(1);
      end
      if (state_q != ST_IDLE && hcs_prev_q && !hcs_s) coll_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (accept_ok) begin
               tx_d  = HDR_W'({OPCODE, addr_wire}) << DUMMY_W;
               rem_d = rd_len;
               sck_d = 1'b0;
               div_d = '0;
               bit_d = '0;
               if (rd_len == '0) begin
                  // Zero-length request: skip the bus, land on the final deselect cycle.
                  state_d = ST_DESEL;
                  dsl_d   = DSL_W'(DESEL - 1);
               end else begin
                  state_d = ST_CMD;
                  dsl_d   = '0;
               end
            end
         end
         ST_CMD, ST_ADDR: begin
            if (!tick) begin
               div_d = div_q + DIV_W'(1);
            end else begin
               div_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d = 1'b0;
                  tx_d  = tx_q << 1;
                  bit_d = bit_q + 6'd1;
                  if (bit_q == 6'd7) state_d = ST_ADDR;
                  if (bit_q == 6'(HDR_W - 1)) begin
                     state_d = ST_DATA;
                     bit_d   = '0;
                  end
               end
            end
         end
         ST_DATA: begin
            if (!tick) begin
               div_d = div_q + DIV_W'(1);
            end else begin
               div_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
                  rx_d  = {rx_q[6:0], flash_d1};
                  if (bit_q == 6'd7) begin
                     data_d  = {rx_q[6:0], flash_d1};
                     valid_d = 1'b1;
                  end
               end else begin
                  sck_d = 1'b0;
                  if (bit_q == 6'd7) begin
                     bit_d = '0;
                     dsl_d = '0;
                     if (!valid_q || rd_ready) state_d = (rem_d == '0) ? ST_DESEL : ST_DATA;
                     else                      state_d = ST_STALL;
                  end else begin
                     bit_d = bit_q + 6'd1;
                  end
               end
            end
         end
         ST_STALL: begin
            dsl_d = '0;
            if (!valid_q || rd_ready) state_d = (rem_d == '0) ? ST_DESEL : ST_DATA;
         end
         ST_DESEL: begin
            if (dsl_q == DSL_W'(DESEL - 1)) begin
               state_d = ST_IDLE;
               dsl_d   = '0;
            end else begin
               dsl_d = dsl_q + DSL_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset overrides the pass-through so the flash is deselected while RST is high.
   assign pass      = (state_q == ST_IDLE) && !RST;
   assign flash_csb = pass ? host_csb  : !(state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_STALL});
   assign flash_sck = pass ? host_sck  : sck_q;
   assign flash_d0  = pass ? host_mosi :
                      ((state_q inside {ST_CMD, ST_ADDR}) ? tx_q[HDR_W-1] : 1'b0);
   assign host_miso = pass ? flash_d1  : 1'b1;
   assign flash_d2  = 1'b1;
   assign flash_d3  = 1'b1;

   assign rd_busy     = (state_q != ST_IDLE) || (accept_ok && !RST);
   assign rd_data     = data_q;
   assign rd_valid    = valid_q;
   assign rd_done     = (state_q == ST_DESEL) && (dsl_q == DSL_W'(DESEL - 1));
   assign host_coll   = coll_q;
   assign dbg_state_o = state_q;

endmodule
